// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD arbiter: FSM states, HD44780 init and clear
// nibble sequences, and the ASCII constants used for character output.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        CLEAR,
        CHAR,
        FIN
    } lcd_state_e;

    // Power-on nibble sequence, first nibble in the top four bits: 2,2,8,0,C,0,6
    localparam logic [27:0] INIT_TABLE  = 28'h2280C06;
    localparam int unsigned INIT_STEPS  = 7;

    // Clear-display command split into high and low nibble
    localparam logic [7:0]  CLEAR_NIBS  = 8'h01;
    localparam int unsigned CLEAR_STEPS = 2;

    localparam int unsigned HEX_CHARS   = 16;

    localparam logic [7:0]  ASC_ZERO    = 8'h30;
    localparam logic [7:0]  ASC_A       = 8'h41;
    localparam logic [7:0]  ASC_D       = 8'h44;
    localparam logic [7:0]  ASC_E       = 8'h45;

    function automatic logic [3:0] init_nib(input logic [2:0] step);
        return 4'(INIT_TABLE >> (5'd24 - {step, 2'b00}));
    endfunction

endpackage

// File: rtl/lcd_hex2ascii.sv
// Converts one hex digit to its upper-case ASCII character code.
module lcd_hex2ascii
    import lcd_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] ascii_o
);

    // Digits map onto '0'..'9', letters onto 'A'..'F'
    always_comb begin
        if (hex_i < 4'd10) begin
            ascii_o = ASC_ZERO + {4'b0000, hex_i};
        end else begin
            ascii_o = ASC_A + {4'b0000, hex_i - 4'd10};
        end
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter between two requesters sharing one HD44780 LCD in
// 4-bit mode. After power-up initialisation, each granted transaction clears
// the display and writes the latched 64-bit word as 16 hex characters.
// Optional macro LCD_ARBITER_TAG_EN prefixes the characters with 'E'
// (requester 0) or 'D' (requester 1).
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned STEP_W = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [63:0] data0,
    input  logic [63:0] data1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [3:0]  lcd_d
);

`ifdef LCD_ARBITER_TAG_EN
    localparam int unsigned CHAR_STEPS = 2 * (HEX_CHARS + 1);
`else
    localparam int unsigned CHAR_STEPS = 2 * HEX_CHARS;
`endif

    lcd_state_e        state_q, state_d;
    logic [STEP_W-1:0] ph_q, ph_d;
    logic [5:0]        idx_q, idx_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              fav_q, fav_d;
    logic [63:0]       data_q, data_d;
    logic              lcd_e_q, lcd_rs_q;
    logic [3:0]        lcd_d_q;

    logic              step_end;
    logic              grant1;
    logic [3:0]        nib;
    logic [3:0]        hex_j;
    logic [3:0]        hex_nib;
    logic [7:0]        hex_ascii;
    logic [7:0]        char_byte;

    assign step_end = &ph_q;
    assign grant1   = req[1] & (~req[0] | fav_q);
    assign hex_nib  = 4'(data_q >> (6'd60 - {hex_j, 2'b00}));

    lcd_hex2ascii u_hex2ascii (
        .hex_i   (hex_nib),
        .ascii_o (hex_ascii)
    );

    // Character slot 0 carries the tag when enabled; hex digits follow
`ifdef LCD_ARBITER_TAG_EN
    assign hex_j     = 4'(idx_q[5:1] - 5'd1);
    assign char_byte = (idx_q[5:1] == 5'd0) ? (gnt_q[1] ? ASC_D : ASC_E) : hex_ascii;
`else
    assign hex_j     = idx_q[4:1];
    assign char_byte = hex_ascii;
`endif

    // Next-state, step sequencing, arbitration and current nibble selection
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        fav_d   = fav_q;
        data_d  = data_q;
        nib     = 4'h0;
        unique case (state_q)
            INIT: begin
                nib  = init_nib(idx_q[2:0]);
                ph_d = ph_q + 1'b1;
                if (step_end) begin
                    if (idx_q == 6'(INIT_STEPS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            IDLE: begin
                ph_d  = '0;
                idx_d = '0;
                if (req != 2'b00) begin
                    state_d = CLEAR;
                    gnt_d   = grant1 ? 2'b10 : 2'b01;
                    data_d  = grant1 ? data1 : data0;
                    fav_d   = ~grant1;
                end
            end
            CLEAR: begin
                nib  = idx_q[0] ? CLEAR_NIBS[3:0] : CLEAR_NIBS[7:4];
                ph_d = ph_q + 1'b1;
                if (step_end) begin
                    if (idx_q == 6'(CLEAR_STEPS - 1)) begin
                        state_d = CHAR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            CHAR: begin
                nib  = idx_q[0] ? char_byte[3:0] : char_byte[7:4];
                ph_d = ph_q + 1'b1;
                if (step_end) begin
                    if (idx_q == 6'(CHAR_STEPS - 1)) begin
                        state_d = FIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                gnt_d   = '0;
                ph_d    = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = INIT;
                gnt_d   = '0;
                ph_d    = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Control-state registers; reset restarts initialisation and favours requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ph_q    <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            fav_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            fav_q   <= fav_d;
            data_q  <= data_d;
        end
    end

    // LCD bus registered from the current step; enable high in the middle half of each step
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_e_q  <= 1'b0;
            lcd_rs_q <= 1'b0;
            lcd_d_q  <= '0;
        end else begin
            lcd_e_q  <= (state_q inside {INIT, CLEAR, CHAR}) & (ph_q[STEP_W-1] ^ ph_q[STEP_W-2]);
            lcd_rs_q <= (state_q == CHAR);
            lcd_d_q  <= nib;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);
    assign lcd_e  = lcd_e_q;
    assign lcd_rs = lcd_rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_d  = lcd_d_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Self-checking bench for lcd_arbiter with 4-cycle LCD steps. Expected bus
// traffic is generated from the character/nibble rules of the display protocol.
module tb_lcd_arbiter;

    localparam int unsigned STEP_W = 2;
    localparam int CYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [63:0] data0 = '0;
    logic [63:0] data1 = '0;
    logic [1:0]  gnt;
    logic        busy, done, lcd_e, lcd_rs, lcd_rw;
    logic [3:0]  lcd_d;

    int n_cmp = 0;
    int n_bad = 0;
    int rr_fav = 0;

    lcd_arbiter #(.STEP_W(STEP_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data0  (data0),
        .data1  (data1),
        .gnt    (gnt),
        .busy   (busy),
        .done   (done),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_d  (lcd_d)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] hex_char(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    // Expected {e, rs, rw, d} for cycle c of a stream; st is {rs, nibble}
    function automatic logic [6:0] bus_exp(input logic [4:0] st, input int c);
        int  ph;
        logic e;
        ph = c % CYC;
        e  = (ph >= CYC / 4) && (ph < 3 * CYC / 4);
        return {e, st[4], 1'b0, st[3:0]};
    endfunction

    task automatic idle_check();
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 0);
        check("idle_done", done, 0);
    endtask

    task automatic check_init();
        int seq[7] = '{2, 2, 8, 0, 12, 0, 6};
        for (int c = 0; c < 7 * CYC; c++) begin
            tick();
            check("init_lcd", {lcd_e, lcd_rs, lcd_rw, lcd_d}, bus_exp({1'b0, 4'(seq[c / CYC])}, c));
            check("init_gnt", gnt, 0);
            check("init_done", done, 0);
            // busy drops as the FSM leaves INIT, while the bus still shows the last step
            if (c < 7 * CYC - 1) check("init_busy", busy, 1);
        end
        idle_check();
    endtask

    task automatic txn(input logic [1:0] r, input bit scramble, input bit drop);
        logic [63:0] word;
        logic [4:0]  q[$];
        logic [7:0]  ch;
        logic [1:0]  g_exp;
        int g, len;
        req   = r;
        g     = (r == 2'b11) ? rr_fav : ((r == 2'b10) ? 1 : 0);
        g_exp = (g == 1) ? 2'b10 : 2'b01;
        word  = (g == 1) ? data1 : data0;
        tick();
        check("gnt", gnt, g_exp);
        check("gnt_busy", busy, 1);
        rr_fav = 1 - g;
        if (scramble) begin
            data0 = ~data0;
            data1 = ~data1;
        end
        if (drop) req = 2'b00;
        q.push_back(5'h00);
        q.push_back(5'h01);
`ifdef LCD_ARBITER_TAG_EN
        ch = (g == 1) ? 8'h44 : 8'h45;
        q.push_back({1'b1, ch[7:4]});
        q.push_back({1'b1, ch[3:0]});
`endif
        for (int k = 0; k < 16; k++) begin
            ch = hex_char(int'((word >> (60 - 4 * k)) & 64'hF));
            q.push_back({1'b1, ch[7:4]});
            q.push_back({1'b1, ch[3:0]});
        end
        len = q.size() * CYC;
        for (int c = 0; c < len; c++) begin
            tick();
            check("lcd", {lcd_e, lcd_rs, lcd_rw, lcd_d}, bus_exp(q[c / CYC], c));
            check("done", done, (c == len - 1) ? 1 : 0);
            check("gnt_hold", gnt, g_exp);
        end
        tick();
        idle_check();
    endtask

    initial begin
        int gap;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 1);
        check("rst_lcd", {lcd_e, lcd_rs, lcd_rw, lcd_d}, 0);
        rst = 1'b0;
        check_init();

        // Both requesting continuously: alternate starting with requester 0
        data0 = {$urandom, $urandom};
        data1 = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) txn(2'b11, 1'b0, 1'b0);

        // Known word, inputs overwritten right after the grant
        data0 = 64'h0123456789ABCDEF;
        txn(2'b01, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 2);
            req = 2'b00;
            repeat (gap) begin
                tick();
                idle_check();
            end
            data0 = {$urandom, $urandom};
            data1 = {$urandom, $urandom};
            txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset during the fifth character aborts without a done pulse
        data0 = {$urandom, $urandom};
        req = 2'b01;
        tick();
        check("abort_gnt", gnt, 2'b01);
        rr_fav = 1;
        req = 2'b00;
        for (int c = 0; c < 43; c++) begin
            tick();
            check("abort_done", done, 0);
        end
        rst = 1'b1;
        tick();
        check("abort_gnt_clr", gnt, 0);
        check("abort_lcd_clr", {lcd_e, lcd_rs, lcd_rw, lcd_d}, 0);
        check("abort_no_done", done, 0);
        check("abort_busy", busy, 1);
        rr_fav = 0;
        rst = 1'b0;
        check_init();

        // Priority pointer was returned to requester 0 by reset
        data0 = {$urandom, $urandom};
        data1 = {$urandom, $urandom};
        txn(2'b11, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
